// File: rtl/qos_pkg.sv
// Shared parameters, state encoding and helpers for the QoS window controller.
package qos_pkg;

  localparam int N_STREAMS = 4;
  localparam int CNT_W     = 8;
  localparam int PKT_W     = 16;
  localparam int TMO_W     = 24;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MEASURE,
    ST_SNAP
  } state_e;

  // A zero packet target would end every window instantly, so floor it at 1.
  function automatic logic [PKT_W-1:0] pkt_target(
    input logic [PKT_W-1:0] window_pkts
  );
    return (window_pkts == '0) ? PKT_W'(1) : window_pkts;
  endfunction

endpackage

// File: rtl/qos_stream_pkt_counter.sv
// Per-stream saturating packet counter with a target-reached flag.
module qos_stream_pkt_counter
  import qos_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             cnt_en,
  input  logic [PKT_W-1:0] target,
  output logic [PKT_W-1:0] count,
  output logic             reached
);

  logic [PKT_W-1:0] cnt_q;
  logic [PKT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + PKT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count   = cnt_q;
  assign reached = (cnt_q >= target);

endmodule

// File: rtl/qos_window_controller.sv
// Sequences loss-counter measurement windows: count, snapshot, alarm, clear.
module qos_window_controller
  import qos_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [N_STREAMS-1:0]       stream_en,
  input  logic [PKT_W-1:0]           window_pkts,
  input  logic [TMO_W-1:0]           timeout_cyc,
  input  logic [CNT_W-1:0]           threshold,
  input  logic [N_STREAMS-1:0]       valid,
  input  logic [N_STREAMS-1:0]       sync,
  input  logic [N_STREAMS*CNT_W-1:0] error_count,
  output logic [N_STREAMS-1:0]       en_reset_counter,
  output logic [N_STREAMS*CNT_W-1:0] err_latched,
  output logic [N_STREAMS-1:0]       alarm,
  output logic [N_STREAMS-1:0]       starved,
  output logic                       window_done,
  output logic                       busy
);

  state_e                     state_q, state_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic                       stop_seen_q, stop_seen_d;
  logic [N_STREAMS-1:0]       en_rst_q, en_rst_d;
  logic [N_STREAMS*CNT_W-1:0] err_q, err_d;
  logic [N_STREAMS-1:0]       alarm_q, alarm_d;
  logic [N_STREAMS-1:0]       starved_q, starved_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;

  logic                 in_measure;
  logic                 in_clear;
  logic [PKT_W-1:0]     target;
  logic [N_STREAMS-1:0] cnt_en;
  logic [N_STREAMS-1:0] reached;
  logic [PKT_W-1:0]     pkt_cnt [N_STREAMS];
  logic                 count_end;
  logic                 tmo_hit;
  logic                 tmo_end;
  logic                 win_end;

  assign in_measure = (state_q == ST_MEASURE);
  assign in_clear   = (state_q == ST_CLEAR);
  assign target     = pkt_target(window_pkts);
  assign cnt_en     = {N_STREAMS{in_measure}} & valid & sync & stream_en;

  for (genvar i = 0; i < N_STREAMS; i++) begin : g_cnt
    qos_stream_pkt_counter u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear   (in_clear),
      .cnt_en  (cnt_en[i]),
      .target  (target),
      .count   (pkt_cnt[i]),
      .reached (reached[i])
    );
  end

  // Disabled streams must not gate; with none enabled only the timeout ends.
  assign count_end = (&(reached | ~stream_en)) & (|stream_en);
  assign tmo_hit   = (timeout_cyc != '0) &&
                     (tmo_q == timeout_cyc - TMO_W'(1));
  assign tmo_end   = tmo_hit & ~count_end;
  assign win_end   = in_measure & (count_end | tmo_hit);

  always_comb begin
    state_d     = state_q;
    stop_seen_d = stop_seen_q;
    unique case (state_q)
      ST_IDLE: begin
        stop_seen_d = 1'b0;
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (stop) stop_seen_d = 1'b1;
        state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (stop) stop_seen_d = 1'b1;
        if (win_end) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        stop_seen_d = 1'b0;
        state_d = (stop_seen_q | stop) ? ST_IDLE : ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmo_d = tmo_q;
    if (in_clear) begin
      tmo_d = '0;
    end else if (in_measure && (tmo_q != '1)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_comb begin
    en_rst_d  = (state_d == ST_CLEAR) ? stream_en : '0;
    done_d    = (state_d == ST_SNAP);
    busy_d    = (state_d != ST_IDLE);
    err_d     = err_q;
    alarm_d   = alarm_q;
    starved_d = starved_q;
    if (win_end) begin
      err_d = error_count;
      for (int i = 0; i < N_STREAMS; i++) begin
        alarm_d[i]   = stream_en[i] &
                       (error_count[i*CNT_W +: CNT_W] > threshold);
        starved_d[i] = tmo_end & stream_en[i] &
                       (pkt_cnt[i] < window_pkts);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      stop_seen_q <= 1'b0;
      en_rst_q    <= '0;
      err_q       <= '0;
      alarm_q     <= '0;
      starved_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      stop_seen_q <= stop_seen_d;
      en_rst_q    <= en_rst_d;
      err_q       <= err_d;
      alarm_q     <= alarm_d;
      starved_q   <= starved_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign en_reset_counter = en_rst_q;
  assign err_latched      = err_q;
  assign alarm            = alarm_q;
  assign starved          = starved_q;
  assign window_done      = done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_qos_window_controller.sv
// Directed bench for qos_window_controller with immediate-assertion checks.
module tb_qos_window_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [3:0]  stream_en;
  logic [15:0] window_pkts;
  logic [23:0] timeout_cyc;
  logic [7:0]  threshold;
  logic [3:0]  valid;
  logic [3:0]  sync;
  logic [31:0] error_count;
  logic [3:0]  en_reset_counter;
  logic [31:0] err_latched;
  logic [3:0]  alarm;
  logic [3:0]  starved;
  logic        window_done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  qos_window_controller dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .stream_en        (stream_en),
    .window_pkts      (window_pkts),
    .timeout_cyc      (timeout_cyc),
    .threshold        (threshold),
    .valid            (valid),
    .sync             (sync),
    .error_count      (error_count),
    .en_reset_counter (en_reset_counter),
    .err_latched      (err_latched),
    .alarm            (alarm),
    .starved          (starved),
    .window_done      (window_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_sync(input logic [3:0] mask);
    valid = mask;
    sync  = mask;
    step();
    valid = '0;
    sync  = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int nd;
    int ne;
    logic [3:0] m;

    reset = 1'b1; start = 0; stop = 0;
    stream_en = 4'hF; window_pkts = 16'd3; timeout_cyc = '0;
    threshold = 8'd4; valid = '0; sync = '0;
    error_count = {8'd0, 8'd9, 8'd2, 8'd5};
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_en", en_reset_counter, 0);
    chk("rst_err", err_latched, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_starved", starved, 0);
    chk("rst_done", window_done, 0);
    reset = 1'b0;
    step();

    stop = 1; step(); stop = 0;
    chk("idle_stop", busy, 0);

    // Test 1/2: count-ended window with alarms.
    start = 1; step(); start = 0;
    chk("t1_clear_en", en_reset_counter, 4'hF);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_meas_en", en_reset_counter, 0);
    start = 1; step(); start = 0;
    chk("busy_start_ign", en_reset_counter, 0);
    send_sync(4'hF); repeat (187) step();
    send_sync(4'hF); repeat (187) step();
    send_sync(4'hF);
    chk("t1_done_early", window_done, 0);
    step();
    chk("t1_done", window_done, 1);
    chk("t2_err", err_latched, 32'h0009_0205);
    chk("t2_alarm", alarm, 4'b0101);
    chk("t1_starved", starved, 0);
    step();
    chk("t1_en_after", en_reset_counter, 4'hF);
    chk("t1_done_pulse", window_done, 0);

    // Test 3: timeout with stream 2 silent.
    window_pkts = 16'd5; timeout_cyc = 24'd2000;
    error_count = {8'd1, 8'd7, 8'd4, 8'd0};
    step();
    c = 0;
    for (int i = 0; i < 2100; i++) begin
      if (window_done) break;
      m = ((i % 188) == 10 && i < 1000) ? 4'b1011 : 4'b0000;
      valid = m; sync = m;
      step();
      c++;
    end
    valid = '0; sync = '0;
    chk("t3_len", c, 2000);
    chk("t3_done", window_done, 1);
    chk("t3_starved", starved, 4'b0100);
    chk("t3_alarm", alarm, 4'b0100);
    chk("t3_err", err_latched, 32'h0107_0400);
    step();
    chk("t3_en", en_reset_counter, 4'hF);

    // Test 4: only streams 0/1 enabled.
    stream_en = 4'b0011; window_pkts = 16'd2; timeout_cyc = '0;
    error_count = 32'h0909_0909;
    step();
    send_sync(4'b0011); repeat (5) step();
    send_sync(4'b0011);
    chk("t4_done_early", window_done, 0);
    step();
    chk("t4_done", window_done, 1);
    chk("t4_starved", starved, 0);
    chk("t4_alarm", alarm, 4'b0011);
    step();
    chk("t4_en", en_reset_counter, 4'b0011);

    // Test 6: window_pkts=0, sync during CLEAR is blind.
    stream_en = 4'hF; window_pkts = 16'd0;
    valid = 4'hF; sync = 4'hF;
    step();
    valid = '0; sync = '0;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (window_done) nd++;
    end
    chk("t6_blind", nd, 0);
    send_sync(4'hF);
    chk("t6_done_early", window_done, 0);
    step();
    chk("t6_done", window_done, 1);
    chk("t6_starved", starved, 0);
    step();
    chk("t6_en", en_reset_counter, 4'hF);

    // Test 5: stop mid-window, counted from this window's CLEAR.
    window_pkts = 16'd2;
    nd = 0; ne = 0;
    for (int i = 0; i < 40; i++) begin
      if (en_reset_counter != 0) ne++;
      if (window_done) nd++;
      stop = (i == 3);
      m = (i == 5 || i == 10) ? 4'hF : 4'h0;
      valid = m; sync = m;
      step();
    end
    stop = 0; valid = '0; sync = '0;
    chk("t5_done_cnt", nd, 1);
    chk("t5_en_cnt", ne, 1);
    chk("t5_busy", busy, 0);
    chk("t5_alarm", alarm, 4'hF);

    // Start beats stop in IDLE; then reset mid-MEASURE.
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("start_wins", busy, 1);
    chk("start_en", en_reset_counter, 4'hF);
    step();
    send_sync(4'hF);
    step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_latched, 0);
    chk("mid_rst_alarm", alarm, 0);
    chk("mid_rst_en", en_reset_counter, 0);
    ne = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (en_reset_counter != 0) ne++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (en_reset_counter != 0) ne++;
    end
    chk("rst_no_pulse", ne, 0);
    chk("rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
